// File: rtl/seq_pkg.sv
// Shared types and constants for the pattern generator slice.
package seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGen,
        StShow,
        StHide,
        StWaitRes
    } state_e;

    localparam logic [7:0] LFSR_MASK = 8'hB8;
    localparam logic [7:0] SCORE_MAX = 8'd255;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Galois LFSR, right-shifting, taps x^8+x^6+x^5+x^4+1.
module lfsr8
    import seq_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [7:0] Q
);

    logic [7:0] lfsr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr_q <= SEED;
        end else if (lfsr_q[0]) begin
            lfsr_q <= (lfsr_q >> 1) ^ LFSR_MASK;
        end else begin
            lfsr_q <= lfsr_q >> 1;
        end
    end

    assign Q = lfsr_q;

endmodule

// File: rtl/seq_pattern_gen.sv
// Challenge generator: shows an LFSR target for a level-scaled window, then
// scores the round from the checker's Z pulse within a bounded wait.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter logic [7:0]  SEED        = 8'hA5,
    parameter int unsigned TMR_W       = 28,
    parameter int unsigned SHOW_CYCLES = 100_000_000,
    parameter int unsigned RESULT_WAIT = 16,
    parameter int unsigned MAX_LEVEL   = 7
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       SUBMIT,
    input  logic       Z,
    output logic [7:0] LEDS,
    output logic [7:0] LED_SHOW,
    output logic [7:0] SCORE,
    output logic [2:0] LEVEL,
    output logic       WIN,
    output logic       LOSE,
    output logic       BUSY
);

    localparam logic [2:0]       LevelMax = 3'(MAX_LEVEL);
    localparam logic [TMR_W-1:0] WaitLoad = TMR_W'(RESULT_WAIT - 1);

    // Timer reload for the show window; never shorter than one cycle.
    function automatic logic [TMR_W-1:0] show_load(input logic [2:0] lvl);
        int unsigned len;
        len = SHOW_CYCLES >> lvl;
        if (len == 0) begin
            len = 1;
        end
        return TMR_W'(len - 1);
    endfunction

    state_e           state_q;
    logic [7:0]       leds_q;
    logic [7:0]       score_q;
    logic [2:0]       level_q;
    logic             win_q;
    logic             lose_q;
    logic [TMR_W-1:0] timer_q;
    logic [7:0]       lfsr;

    lfsr8 #(
        .SEED(SEED)
    ) u_lfsr (
        .CLK(CLK),
        .RST(RST),
        .Q  (lfsr)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            leds_q  <= '0;
            score_q <= '0;
            level_q <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            win_q  <= 1'b0;
            lose_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        score_q <= '0;
                        level_q <= '0;
                        state_q <= StGen;
                    end
                end
                StGen: begin
                    leds_q  <= lfsr;
                    timer_q <= show_load(level_q);
                    state_q <= StShow;
                end
                StShow: begin
                    if (SUBMIT) begin
                        lose_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (timer_q == '0) begin
                        state_q <= StHide;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                StHide: begin
                    if (SUBMIT) begin
                        timer_q <= WaitLoad;
                        state_q <= StWaitRes;
                    end
                end
                StWaitRes: begin
                    // A match on the final wait cycle still counts as a win.
                    if (Z) begin
                        win_q <= 1'b1;
                        if (score_q != SCORE_MAX) begin
                            score_q <= score_q + 8'd1;
                        end
                        if (level_q != LevelMax) begin
                            level_q <= level_q + 3'd1;
                        end
                        state_q <= StGen;
                    end else if (timer_q == '0) begin
                        lose_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign LEDS     = leds_q;
    assign SCORE    = score_q;
    assign LEVEL    = level_q;
    assign WIN      = win_q;
    assign LOSE     = lose_q;
    assign BUSY     = (state_q != StIdle);
    assign LED_SHOW = (state_q == StShow) ? leds_q : 8'h00;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench with a per-cycle behavioural model of the game rules.
module tb_seq_pattern_gen;

    localparam int unsigned SC = 16;
    localparam int unsigned RW = 12;
    localparam int unsigned ML = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       SUBMIT = 1'b0;
    logic       Z = 1'b0;
    logic [7:0] LEDS, LED_SHOW, SCORE;
    logic [2:0] LEVEL;
    logic       WIN, LOSE, BUSY;

    int n_checks = 0;
    int n_errors = 0;

    seq_pattern_gen #(
        .SEED       (8'hA5),
        .TMR_W      (28),
        .SHOW_CYCLES(SC),
        .RESULT_WAIT(RW),
        .MAX_LEVEL  (ML)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .SUBMIT  (SUBMIT),
        .Z       (Z),
        .LEDS    (LEDS),
        .LED_SHOW(LED_SHOW),
        .SCORE   (SCORE),
        .LEVEL   (LEVEL),
        .WIN     (WIN),
        .LOSE    (LOSE),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: game phases with "cycles left" counters.
    localparam int P_IDLE = 0, P_GEN = 1, P_SHOW = 2, P_HIDE = 3, P_WAIT = 4;
    int         m_phase = P_IDLE;
    int         m_left = 0;
    int         m_score = 0;
    int         m_level = 0;
    logic [7:0] m_lfsr = 8'h00;
    logic [7:0] m_leds = 8'h00;
    bit         m_win = 0, m_lose = 0, m_valid = 0;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    function automatic int window(input int lvl);
        int w;
        w = SC >> lvl;
        return (w < 1) ? 1 : w;
    endfunction

    always @(posedge CLK) begin
        m_win  = 0;
        m_lose = 0;
        if (RST) begin
            m_valid = 1;
            m_phase = P_IDLE;
            m_lfsr  = 8'hA5;
            m_leds  = 8'h00;
            m_score = 0;
            m_level = 0;
            m_left  = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (START) begin
                    m_score = 0;
                    m_level = 0;
                    m_phase = P_GEN;
                end
                P_GEN: begin
                    m_leds  = m_lfsr;
                    m_left  = window(m_level);
                    m_phase = P_SHOW;
                end
                P_SHOW: if (SUBMIT) begin
                    m_lose  = 1;
                    m_phase = P_IDLE;
                end else begin
                    m_left--;
                    if (m_left == 0) m_phase = P_HIDE;
                end
                P_HIDE: if (SUBMIT) begin
                    m_left  = RW;
                    m_phase = P_WAIT;
                end
                P_WAIT: if (Z) begin
                    m_win   = 1;
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    m_level = (m_level < ML) ? m_level + 1 : ML;
                    m_phase = P_GEN;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_lose  = 1;
                        m_phase = P_IDLE;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("cycle", {2'b0, LEDS, LED_SHOW, SCORE, LEVEL, WIN, LOSE, BUSY},
                {2'b0, m_leds, (m_phase == P_SHOW) ? m_leds : 8'h00, 8'(m_score),
                 3'(m_level), m_win, m_lose, m_phase != P_IDLE});
        end
    end

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic pulse_submit();
        SUBMIT = 1'b1;
        @(negedge CLK);
        SUBMIT = 1'b0;
    endtask

    task automatic pulse_z();
        Z = 1'b1;
        @(negedge CLK);
        Z = 1'b0;
    endtask

    // Waits for the show window, returns its length and displayed pattern.
    task automatic measure_show(output int len, output logic [7:0] first);
        int t;
        t   = 0;
        len = 0;
        while (LED_SHOW == 8'h00 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 200) chk("show_start_timeout", 32'd1, 32'd0);
        first = LED_SHOW;
        while (LED_SHOW != 8'h00 && len < 1000) begin
            len++;
            @(negedge CLK);
        end
    endtask

    task automatic win_round();
        int         len;
        logic [7:0] pat;
        measure_show(len, pat);
        pulse_submit();
        repeat (9) @(negedge CLK);
        pulse_z();
    endtask

    initial begin
        int         len, k;
        logic [7:0] pat, prev;
        int         exp_len[5];
        exp_len = '{16, 8, 4, 2, 2};

        // Reset, then START on the first edge after RST falls
        repeat (3) @(negedge CLK);
        chk("reset_leds", 32'(LEDS), 32'h00);
        chk("reset_busy", 32'(BUSY), 32'd0);
        RST = 1'b0;
        pulse_start();
        chk("gen_busy", 32'(BUSY), 32'd1);
        measure_show(len, pat);
        chk("first_pattern", 32'(pat), 32'hEA);
        chk("first_leds", 32'(LEDS), 32'hEA);
        chk("show_len_l0", 32'(len), 32'd16);

        // Submit, Z on the tenth wait cycle: win
        pulse_submit();
        repeat (9) @(negedge CLK);
        pulse_z();
        chk("win_pulse", 32'(WIN), 32'd1);
        chk("win_score", 32'(SCORE), 32'd1);
        chk("win_level", 32'(LEVEL), 32'd1);
        prev = LEDS;
        measure_show(len, pat);
        chk("new_pattern", 32'(LEDS != prev), 32'd1);
        chk("show_len_l1", 32'(len), 32'd8);

        // Submit with no Z: lose after the full wait
        pulse_submit();
        k = 0;
        while (!LOSE && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("lose_latency", 32'(k), 32'd12);
        chk("lose_idle", 32'(BUSY), 32'd0);
        chk("lose_score_held", 32'(SCORE), 32'd1);
        chk("lose_level_held", 32'(LEVEL), 32'd1);
        @(negedge CLK);
        pulse_start();
        chk("start_clears_score", 32'(SCORE), 32'd0);
        chk("start_clears_level", 32'(LEVEL), 32'd0);

        // Early submit during SHOW, then a stray Z
        k = 0;
        while (LED_SHOW == 8'h00 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        pulse_submit();
        chk("early_lose", 32'(LOSE), 32'd1);
        chk("early_idle", 32'(BUSY), 32'd0);
        repeat (9) @(negedge CLK);
        pulse_z();
        chk("stray_z_no_win", 32'(WIN), 32'd0);

        // Five consecutive wins with level saturation
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            measure_show(len, pat);
            chk("show_len_seq", 32'(len), 32'(exp_len[i]));
            pulse_submit();
            repeat (9) @(negedge CLK);
            pulse_z();
            chk("seq_win", 32'(WIN), 32'd1);
        end
        chk("five_score", 32'(SCORE), 32'd5);
        chk("five_level", 32'(LEVEL), 32'd3);

        // Score saturation at 255
        for (int i = 0; i < 250; i++) win_round();
        chk("score_255", 32'(SCORE), 32'd255);
        win_round();
        chk("sat_win", 32'(WIN), 32'd1);
        chk("score_sat", 32'(SCORE), 32'd255);

        // Reset in the middle of WAIT_RES
        measure_show(len, pat);
        pulse_submit();
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_no_win", 32'(WIN), 32'd0);
        chk("rst_no_lose", 32'(LOSE), 32'd0);
        chk("rst_outputs", {8'h0, LEDS, SCORE, 5'(LEVEL), 2'(BUSY)}, 32'h0);
        RST = 1'b0;
        pulse_start();
        measure_show(len, pat);
        chk("rst_lfsr_restart", 32'(pat), 32'hEA);

        // Z on the final wait cycle wins
        pulse_submit();
        repeat (11) @(negedge CLK);
        pulse_z();
        chk("last_cycle_win", 32'(WIN), 32'd1);
        chk("last_cycle_no_lose", 32'(LOSE), 32'd0);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
